// File: rtl/eth_wb_pkg.sv
// Shared widths, FSM states and the latched request record for the Ethernet MAC Wishbone host.
package eth_wb_pkg;
  localparam int WB_AW = 10;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;

  typedef enum logic [1:0] {IDLE, BUS, RESP} wb_host_st_e;

  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] adr;
    logic [WB_SW-1:0] sel;
    logic [WB_DW-1:0] dat;
  } wb_req_t;
endpackage

// File: rtl/eth_rr_arb.sv
// Round-robin grant: one-hot on the first requester at or after ptr_i, all zero when disabled.
module eth_rr_arb #(
  parameter  int NUM_REQ = 2,
  localparam int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o
);
  int   idx;
  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_i) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule

// File: rtl/eth_wb_host_arb.sv
// Round-robin shared Wishbone classic master for the Ethernet MAC register/BD port.
// Optional bus timeout abort is enabled by defining WB_TIMEOUT_EN.
module eth_wb_host_arb
  import eth_wb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ-1:0]       req_we_i,
  input  logic [NUM_REQ*WB_AW-1:0] req_adr_i,
  input  logic [NUM_REQ*WB_SW-1:0] req_sel_i,
  input  logic [NUM_REQ*WB_DW-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]       rsp_valid_o,
  output logic [WB_DW-1:0]         rsp_dat_o,
  output logic                     rsp_err_o,
  output logic                     rsp_tmo_o,
  output logic [WB_AW-1:0]         wb_adr_o,
  output logic [WB_DW-1:0]         wb_dat_o,
  output logic [WB_SW-1:0]         wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_stb_o,
  output logic                     wb_cyc_o,
  input  logic [WB_DW-1:0]         wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i
);
  localparam int PW = $clog2(NUM_REQ);

  wb_host_st_e        state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  wb_req_t            req_q, req_d, g_req;
  logic [NUM_REQ-1:0] owner_q, owner_d, grant;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [WB_DW-1:0]   rsp_dat_q, rsp_dat_d;
  logic               rsp_err_q, rsp_err_d, rsp_tmo_q, rsp_tmo_d;
  logic               cyc_q, cyc_d;
  logic               tmo_hit;
  int                 g_idx;

  eth_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (state_q == IDLE),
    .gnt_o (grant)
  );

`ifdef WB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  // Counter sits at 0 outside BUS, so it is cleared on every BUS entry.
  assign tmo_hit = (cnt_q == 8'(TIMEOUT_CYC - 1));
  always_comb cnt_d = (state_q == BUS) ? cnt_q + 8'd1 : 8'd0;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    g_req = '0;
    g_idx = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        g_idx     = i;
        g_req.we  = req_we_i[i];
        g_req.adr = req_adr_i[i*WB_AW +: WB_AW];
        g_req.sel = req_sel_i[i*WB_SW +: WB_SW];
        g_req.dat = req_dat_i[i*WB_DW +: WB_DW];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    req_d       = req_q;
    owner_d     = owner_q;
    rsp_valid_d = '0;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    cyc_d       = cyc_q;
    case (state_q)
      IDLE: if (|grant) begin
        req_d   = g_req;
        owner_d = grant;
        ptr_d   = (g_idx == NUM_REQ - 1) ? '0 : PW'(g_idx + 1);
        cyc_d   = 1'b1;
        state_d = BUS;
      end
      BUS: if (wb_err_i || wb_ack_i || tmo_hit) begin
        // err beats ack, and a real termination beats the timeout in the same cycle
        cyc_d       = 1'b0;
        rsp_valid_d = owner_q;
        rsp_err_d   = wb_err_i || !wb_ack_i;
        rsp_tmo_d   = !wb_err_i && !wb_ack_i;
        rsp_dat_d   = (wb_ack_i && !wb_err_i && !req_q.we) ? wb_dat_i : '0;
        state_d     = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      req_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      req_q       <= req_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
      cyc_q       <= cyc_d;
    end
  end

  assign req_ready_o = grant;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign wb_adr_o    = req_q.adr;
  assign wb_dat_o    = req_q.dat;
  assign wb_sel_o    = req_q.sel;
  assign wb_we_o     = req_q.we;
  assign wb_stb_o    = cyc_q;
  assign wb_cyc_o    = cyc_q;
endmodule

// File: tb/tb_eth_wb_host_arb.sv
// Directed bench for eth_wb_host_arb: write, RR alternation, read, err+ack, timeout, mid-BUS reset.
module tb_eth_wb_host_arb;
  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic [1:0]  req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
  logic [19:0] req_adr_i;
  logic [7:0]  req_sel_i;
  logic [63:0] req_dat_i;
  logic [31:0] rsp_dat_o, wb_dat_o, wb_dat_i;
  logic        rsp_err_o, rsp_tmo_o, wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i, wb_err_i;
  logic [9:0]  wb_adr_o;
  logic [3:0]  wb_sel_o;
  int          errs = 0;
  int          checks = 0;

  eth_wb_host_arb #(.NUM_REQ(2), .TIMEOUT_CYC(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_adr_i(req_adr_i), .req_sel_i(req_sel_i), .req_dat_i(req_dat_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o), .rsp_tmo_o(rsp_tmo_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cyc"}, {31'd0, wb_cyc_o}, 32'd0);
    chk({tag, "_stb"}, {31'd0, wb_stb_o}, 32'd0);
    chk({tag, "_we"}, {31'd0, wb_we_o}, 32'd0);
    chk({tag, "_adr"}, {22'd0, wb_adr_o}, 32'd0);
    chk({tag, "_sel"}, {28'd0, wb_sel_o}, 32'd0);
    chk({tag, "_wdat"}, wb_dat_o, 32'd0);
    chk({tag, "_rvld"}, {30'd0, rsp_valid_o}, 32'd0);
    chk({tag, "_rdat"}, rsp_dat_o, 32'd0);
    chk({tag, "_rerr"}, {31'd0, rsp_err_o}, 32'd0);
    chk({tag, "_rtmo"}, {31'd0, rsp_tmo_o}, 32'd0);
    chk({tag, "_rdy"}, {30'd0, req_ready_o}, 32'd0);
  endtask

  initial begin
    wb_rst_i = 1'b1; req_valid_i = '0; req_we_i = '0; req_adr_i = '0; req_sel_i = '0;
    req_dat_i = '0; wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    step(); step();
    chk_all_zero("reset");
    wb_rst_i = 1'b0;
    step();

    // 1: req0 write, ack two cycles after stb rises
    req_valid_i = 2'b01; req_we_i = 2'b01; req_adr_i[9:0] = 10'h040;
    req_sel_i[3:0] = 4'hF; req_dat_i[31:0] = 32'hDEADBEEF;
    #1 chk("t1_ready", {30'd0, req_ready_o}, 32'h1);
    step();
    req_valid_i = '0;
    chk("t1_cyc", {31'd0, wb_cyc_o}, 32'h1);
    chk("t1_stb", {31'd0, wb_stb_o}, 32'h1);
    chk("t1_we", {31'd0, wb_we_o}, 32'h1);
    chk("t1_adr", {22'd0, wb_adr_o}, 32'h040);
    chk("t1_sel", {28'd0, wb_sel_o}, 32'hF);
    chk("t1_wdat", wb_dat_o, 32'hDEADBEEF);
    #1 chk("t1_ready_bus", {30'd0, req_ready_o}, 32'h0);
    step();
    chk("t1_cyc_wait", {31'd0, wb_cyc_o}, 32'h1);
    chk("t1_rvld_wait", {30'd0, rsp_valid_o}, 32'h0);
    step();
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk("t1_rvld", {30'd0, rsp_valid_o}, 32'h1);
    chk("t1_rerr", {31'd0, rsp_err_o}, 32'h0);
    chk("t1_cyc_drop", {31'd0, wb_cyc_o}, 32'h0);
    step();
    chk("t1_rvld_once", {30'd0, rsp_valid_o}, 32'h0);

    // 3: req1 read returns slave data (pointer is now 1)
    req_valid_i = 2'b10; req_we_i = 2'b00; req_adr_i[19:10] = 10'h000;
    #1 chk("t3_ready", {30'd0, req_ready_o}, 32'h2);
    step();
    req_valid_i = '0;
    chk("t3_we", {31'd0, wb_we_o}, 32'h0);
    chk("t3_adr", {22'd0, wb_adr_o}, 32'h000);
    wb_ack_i = 1'b1; wb_dat_i = 32'h0000A00B;
    step();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk("t3_rvld", {30'd0, rsp_valid_o}, 32'h2);
    chk("t3_rdat", rsp_dat_o, 32'h0000A00B);
    chk("t3_rerr", {31'd0, rsp_err_o}, 32'h0);
    step();

    // 2: both requesters valid continuously -> 0,1,0,1,...
    req_valid_i = 2'b11; req_we_i = 2'b00;
    req_adr_i = {10'h222, 10'h111};
    for (int k = 0; k < 8; k++) begin
      #1 chk($sformatf("t2_ready%0d", k), {30'd0, req_ready_o}, (k % 2) ? 32'h2 : 32'h1);
      step();
      chk($sformatf("t2_adr%0d", k), {22'd0, wb_adr_o}, (k % 2) ? 32'h222 : 32'h111);
      wb_ack_i = 1'b1; wb_dat_i = 32'h100 + k;
      step();
      wb_ack_i = 1'b0;
      chk($sformatf("t2_rvld%0d", k), {30'd0, rsp_valid_o}, (k % 2) ? 32'h2 : 32'h1);
      chk($sformatf("t2_rdat%0d", k), rsp_dat_o, 32'h100 + k);
      step();
    end
    req_valid_i = '0;

    // ack/err while idle must not produce anything
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    step();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    step();
    chk("idle_ack_rvld", {30'd0, rsp_valid_o}, 32'h0);
    chk("idle_ack_cyc", {31'd0, wb_cyc_o}, 32'h0);

    // 4: ack and err together on a read -> err wins, data zeroed
    req_valid_i = 2'b01; req_we_i = 2'b00; req_adr_i[9:0] = 10'h3FF;
    step();
    req_valid_i = '0;
    chk("t4_adr", {22'd0, wb_adr_o}, 32'h3FF);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'hFFFFFFFF;
    step();
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_dat_i = 32'h0;
    chk("t4_rvld", {30'd0, rsp_valid_o}, 32'h1);
    chk("t4_rerr", {31'd0, rsp_err_o}, 32'h1);
    chk("t4_rdat", rsp_dat_o, 32'h0);
    chk("t4_rtmo", {31'd0, rsp_tmo_o}, 32'h0);
    chk("t4_cyc", {31'd0, wb_cyc_o}, 32'h0);
    step();

    // 5: slave never answers (pointer is now 1)
    req_valid_i = 2'b10; req_we_i = 2'b10; req_adr_i[19:10] = 10'h155;
    step();
    req_valid_i = '0;
    for (int k = 0; k < 15; k++) step();
    chk("t5_cyc_16th", {31'd0, wb_cyc_o}, 32'h1);
    step();
`ifdef WB_TIMEOUT_EN
    chk("t5_cyc_abort", {31'd0, wb_cyc_o}, 32'h0);
    chk("t5_rvld", {30'd0, rsp_valid_o}, 32'h2);
    chk("t5_rerr", {31'd0, rsp_err_o}, 32'h1);
    chk("t5_rtmo", {31'd0, rsp_tmo_o}, 32'h1);
    chk("t5_rdat", rsp_dat_o, 32'h0);
    step();
    // re-enter BUS so the reset test below starts mid-transaction (pointer back to 0)
    req_valid_i = 2'b01; req_we_i = 2'b00; req_adr_i[9:0] = 10'h0AA;
    step();
    req_valid_i = '0;
`else
    chk("t5_cyc_hold", {31'd0, wb_cyc_o}, 32'h1);
    chk("t5_rvld", {30'd0, rsp_valid_o}, 32'h0);
    chk("t5_rtmo", {31'd0, rsp_tmo_o}, 32'h0);
`endif
    chk("t6_in_bus", {31'd0, wb_cyc_o}, 32'h1);

    // 6: reset pulsed in BUS
    wb_rst_i = 1'b1;
    step();
    chk_all_zero("t6_rst");
    wb_rst_i = 1'b0;
    step();
    chk("t6_no_rsp", {30'd0, rsp_valid_o}, 32'h0);
    req_valid_i = 2'b11; req_we_i = 2'b00; req_adr_i = {10'h2C3, 10'h13C};
    #1 chk("t6_ptr0", {30'd0, req_ready_o}, 32'h1);
    step();
    req_valid_i = '0;
    chk("t6_adr", {22'd0, wb_adr_o}, 32'h13C);
    wb_ack_i = 1'b1; wb_dat_i = 32'h12345678;
    step();
    wb_ack_i = 1'b0;
    chk("t6_rvld", {30'd0, rsp_valid_o}, 32'h1);
    chk("t6_rdat", rsp_dat_o, 32'h12345678);
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
